// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI controller arbiter: FSM states,
// address decode prefixes and bus widths.
package spi_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  localparam logic [4:0] ADC_PREFIX = 5'b00001;
  localparam logic [4:0] DAC_PREFIX = 5'b00010;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_END,
    DONE
  } state_t;

  // ADC accepts reads and writes; the DAC has no readback path.
  function automatic logic is_legal(input logic [4:0] prefix, input logic write);
    return (prefix == ADC_PREFIX) || ((prefix == DAC_PREFIX) && write);
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request at or
// after ptr, wrapping cyclically, plus a flag when any request is set.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Scan from the farthest offset down so the closest hit wins.
  always_comb begin
    idx = ptr;
    any = 1'b0;
    j   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_controller among NUM_REQ requesters.
// Define SPI_ARB_BURST_EN to add req_lock, which keeps priority on the granted requester.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int START_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [ADDR_W*NUM_REQ-1:0] req_address,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
`ifdef SPI_ARB_BURST_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      spi_write_req,
  output logic                      spi_read_req,
  output logic [ADDR_W-1:0]         spi_address,
  output logic [DATA_W-1:0]         spi_data_write,
  input  logic                      spi_busy,
  input  logic [DATA_W-1:0]         spi_data_read
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(START_WAIT + 1);

  state_t              state, state_next;
  logic [IW-1:0]       grant, grant_next, ptr, ptr_next, pick_idx;
  logic                pick_any, lock_hold;
  logic                wr, wr_next, err, err_next;
  logic [ADDR_W-1:0]   addr, addr_next;
  logic [DATA_W-1:0]   wdata, wdata_next, rdata, rdata_next;
  logic [CW-1:0]       cnt, cnt_next;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef SPI_ARB_BURST_EN
  assign lock_hold = req_lock[grant];
`else
  assign lock_hold = 1'b0;
`endif

  assign req_rdata = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      wr    <= 1'b0;
      err   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
      wr    <= wr_next;
      err   <= err_next;
      addr  <= addr_next;
      wdata <= wdata_next;
      rdata <= rdata_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = grant;
    ptr_next       = ptr;
    wr_next        = wr;
    err_next       = err;
    addr_next      = addr;
    wdata_next     = wdata;
    rdata_next     = rdata;
    cnt_next       = cnt;
    req_done       = '0;
    req_err        = 1'b0;
    spi_write_req  = 1'b0;
    spi_read_req   = 1'b0;
    spi_address    = '0;
    spi_data_write = '0;

    if (state inside {ISSUE, WAIT_START, WAIT_END}) begin
      spi_address    = addr;
      spi_data_write = wdata;
    end

    case (state)
      IDLE: begin
        if (pick_any && !spi_busy) begin
          grant_next = pick_idx;
          wr_next    = req_write[pick_idx];
          addr_next  = req_address[ADDR_W*int'(pick_idx) +: ADDR_W];
          wdata_next = req_wdata[DATA_W*int'(pick_idx) +: DATA_W];
          err_next   = 1'b0;
          if (is_legal(addr_next[15:11], wr_next)) begin
            state_next = ISSUE;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end
      end
      ISSUE: begin
        spi_write_req = wr;
        spi_read_req  = !wr;
        cnt_next      = CW'(1);
        state_next    = WAIT_START;
      end
      // cnt counts cycles since ISSUE so the abort lands exactly START_WAIT cycles later.
      WAIT_START: begin
        if (spi_busy) begin
          state_next = WAIT_END;
        end else if (int'(cnt) >= START_WAIT - 1) begin
          state_next = DONE;
          err_next   = 1'b1;
          rdata_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_END: begin
        if (!spi_busy) begin
          rdata_next = spi_data_read;
          err_next   = 1'b0;
          state_next = DONE;
        end
      end
      DONE: begin
        req_done[grant] = 1'b1;
        req_err         = err;
        ptr_next        = lock_hold ? grant :
                          ((int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1);
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
